// File: rtl/posit_enc_pkg.sv
// Shared field widths, the NaR constant and the scheduler state encoding
// for the posit encoder scheduler.
package posit_enc_pkg;

  localparam int K_W     = 6;
  localparam int EXP_W   = 3;
  localparam int MANT_W  = 32;
  localparam int POSIT_W = 32;

  localparam logic [POSIT_W-1:0] POSIT_NAR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/posit_enc_sched_if.sv
// Request/result bundle between the arithmetic cores (master) and the
// encoder scheduler (slave).
interface posit_enc_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 3
);
  import posit_enc_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_sign;
  logic [K_W*NUM_REQ-1:0]     req_k;
  logic [EXP_W*NUM_REQ-1:0]   req_exp;
  logic [MANT_W*NUM_REQ-1:0]  req_mant;

  logic                       res_valid;
  logic                       res_ready;
  logic [POSIT_W-1:0]         res_posit;
  logic [TAG_W-1:0]           res_tag;
  logic                       res_err;

  modport master (
    output req_valid, req_sign, req_k, req_exp, req_mant, res_ready,
    input  req_ready, res_valid, res_posit, res_tag, res_err
  );

  modport slave (
    input  req_valid, req_sign, req_k, req_exp, req_mant, res_ready,
    output req_ready, res_valid, res_posit, res_tag, res_err
  );

endinterface

// File: rtl/posit_enc_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // rotating priority search starting at ptr
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      cand = int'(ptr) + o;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/posit_enc_sched.sv
// Shares one posit encoder between NUM_REQ producers: arbitrates, latches
// the winner's fields, runs the encoder start/done handshake and returns
// the tagged posit on the result port.
// Optional build macro POSIT_ENC_WDOG_EN adds an encoder watchdog that
// aborts a hung run with NaR and res_err=1.
//
//   state  | meaning
//   IDLE   | arbitrating, req_ready offered to the grant
//   LAUNCH | operands latched, enc_start high for this one cycle
//   WAIT   | waiting for enc_done (or watchdog limit)
//   HOLD   | result presented until res_ready
module posit_enc_sched
  import posit_enc_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TAG_W       = 3,
  parameter int WDOG_CYCLES = 63
) (
  input  logic                clk,
  input  logic                rst,
  posit_enc_sched_if.slave    bus,
  output logic                busy,
  output logic                enc_rst_n,
  output logic                enc_start,
  output logic                enc_sign,
  output logic [K_W-1:0]      enc_k,
  output logic [EXP_W-1:0]    enc_exp,
  output logic [MANT_W-1:0]   enc_mant,
  input  logic [POSIT_W-1:0]  enc_p,
  input  logic                enc_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_found;
  logic               wdog_fire;
  logic [POSIT_W-1:0] res_posit_q;
  logic [TAG_W-1:0]   res_tag_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  // next-state and handshake decode
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    enc_start     = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = gnt;
        if (gnt_found) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        enc_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (enc_done || wdog_fire) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy          = (state != ST_IDLE);
  assign bus.res_valid = (state == ST_HOLD);
  assign bus.res_posit = res_posit_q;
  assign bus.res_tag   = res_tag_q;

  // state, pointer, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      res_posit_q <= '0;
      res_tag_q   <= '0;
      enc_sign    <= 1'b0;
      enc_k       <= '0;
      enc_exp     <= '0;
      enc_mant    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && gnt_found) begin
        enc_sign  <= bus.req_sign[gnt_idx];
        enc_k     <= bus.req_k[K_W*int'(gnt_idx) +: K_W];
        enc_exp   <= bus.req_exp[EXP_W*int'(gnt_idx) +: EXP_W];
        enc_mant  <= bus.req_mant[MANT_W*int'(gnt_idx) +: MANT_W];
        res_tag_q <= TAG_W'(gnt_idx);
        if (int'(gnt_idx) == NUM_REQ - 1) rr_ptr <= '0;
        else                              rr_ptr <= gnt_idx + 1'b1;
      end
      if (state == ST_WAIT && enc_done) res_posit_q <= enc_p;
      else if (wdog_fire)               res_posit_q <= POSIT_NAR;
    end
  end

  // encoder reset follows rst one cycle late; a watchdog abort pulses it
  always_ff @(posedge clk) begin
    enc_rst_n <= !rst && !wdog_fire;
  end

`ifdef POSIT_ENC_WDOG_EN
  localparam int WC_W = $clog2(WDOG_CYCLES + 1);
  logic [WC_W-1:0] wdog_cnt;
  logic            res_err_q;

  // counts WAIT cycles; cleared while launching
  always_ff @(posedge clk) begin
    if (rst || state == ST_LAUNCH) wdog_cnt <= '0;
    else if (state == ST_WAIT)     wdog_cnt <= wdog_cnt + 1'b1;
  end

  // enc_done on the limit cycle wins over the abort
  assign wdog_fire = (state == ST_WAIT) && !enc_done &&
                     (wdog_cnt == WC_W'(WDOG_CYCLES - 1));

  // error flag travels with the result it describes
  always_ff @(posedge clk) begin
    if (rst)                          res_err_q <= 1'b0;
    else if (state == ST_WAIT && enc_done) res_err_q <= 1'b0;
    else if (wdog_fire)               res_err_q <= 1'b1;
  end

  assign bus.res_err = res_err_q;
`else
  assign wdog_fire   = 1'b0;
  assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_posit_enc_sched.sv
// Self-checking bench for posit_enc_sched with a behavioural posit
// encoder model (es=3) and a request/result scoreboard.
module tb_posit_enc_sched;
  import posit_enc_pkg::*;

  localparam int NR = 3;
  localparam int TW = 3;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_enc_sched_if #(.NUM_REQ(NR), .TAG_W(TW)) bus ();

  logic        busy, enc_rst_n, enc_start, enc_sign;
  logic [5:0]  enc_k;
  logic [2:0]  enc_exp;
  logic [31:0] enc_mant;
  logic [31:0] enc_p    = '0;
  logic        enc_done = 1'b0;

  posit_enc_sched #(.NUM_REQ(NR), .TAG_W(TW), .WDOG_CYCLES(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .enc_rst_n (enc_rst_n),
    .enc_start (enc_start),
    .enc_sign  (enc_sign),
    .enc_k     (enc_k),
    .enc_exp   (enc_exp),
    .enc_mant  (enc_mant),
    .enc_p     (enc_p),
    .enc_done  (enc_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   posit;
  } exp_t;
  exp_t sb[$];

  int lat       = 3;
  bit suppress  = 1'b0;
  int start_cnt = 0;
  int rstn_low  = 0;
  bit m_run     = 1'b0;
  int m_cnt     = 0;

  function automatic logic [31:0] enc_model(input logic s, input logic signed [5:0] k,
                                            input logic [2:0] e, input logic [31:0] m);
    logic [63:0] body;
    logic [31:0] mag;
    int pos;
    int kk;
    body = '0;
    pos  = 63;
    kk   = int'(k);
    if (kk >= 0) begin
      for (int i = 0; i <= kk; i++) begin body[pos] = 1'b1; pos--; end
      body[pos] = 1'b0; pos--;
    end else begin
      for (int i = 0; i < -kk; i++) begin body[pos] = 1'b0; pos--; end
      body[pos] = 1'b1; pos--;
    end
    for (int i = 2; i >= 0; i--) begin body[pos] = e[i]; pos--; end
    for (int i = 31; i >= 0; i--) if (pos >= 0) begin body[pos] = m[i]; pos--; end
    mag = {1'b0, body[63:33]};
    return s ? (~mag + 32'd1) : mag;
  endfunction

  // scoreboard push on request handshake, plus pulse counters
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{tag: TW'(i),
                         posit: enc_model(bus.req_sign[i], bus.req_k[6*i +: 6],
                                          bus.req_exp[3*i +: 3], bus.req_mant[32*i +: 32])});
      if (enc_start)  start_cnt++;
      if (!enc_rst_n) rstn_low++;
    end
  end

  // encoder model: done rises lat cycles after start, held until next start/reset
  always @(posedge clk) begin
    if (rst || !enc_rst_n) begin
      enc_done <= 1'b0;
      m_run    <= 1'b0;
      m_cnt    <= 0;
    end else if (enc_start) begin
      enc_done <= 1'b0;
      m_run    <= 1'b1;
      m_cnt    <= lat;
      enc_p    <= enc_model(enc_sign, enc_k, enc_exp, enc_mant);
    end else if (m_run) begin
      if (m_cnt <= 1) begin
        m_run    <= 1'b0;
        enc_done <= !suppress;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic rand_fields();
    for (int i = 0; i < NR; i++) begin
      int t;
      t = int'($urandom_range(0, 61)) - 31;
      bus.req_sign[i]        = 1'($urandom_range(0, 1));
      bus.req_k[6*i +: 6]    = 6'(t);
      bus.req_exp[3*i +: 3]  = 3'($urandom_range(0, 7));
      bus.req_mant[32*i +: 32] = $urandom;
    end
  endtask

  // one-shot request; returns at the first negedge with res_valid
  task automatic run_req(input logic [NR-1:0] v, input int lim, output bit got, output int cyc);
    @(negedge clk); bus.req_valid = v;
    @(negedge clk); bus.req_valid = '0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (bus.res_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    rand_fields();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_err++; $display("FAIL rst_req_ready: got %b want 000", bus.req_ready); end
    n_cmp++; if (enc_start !== 1'b0) begin n_err++; $display("FAIL rst_enc_start: got %b want 0", enc_start); end
    n_cmp++; if (enc_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_enc_rst_n: got %b want 0", enc_rst_n); end
    n_cmp++; if ({bus.res_tag, bus.res_posit, bus.res_err} !== 36'h0) begin n_err++; $display("FAIL rst_result: got tag=%0d posit=%h err=%b want 0/0/0", bus.res_tag, bus.res_posit, bus.res_err); end
    n_cmp++; if ({enc_sign, enc_k, enc_exp, enc_mant} !== 42'h0) begin n_err++; $display("FAIL rst_operands: got %h want 0", {enc_sign, enc_k, enc_exp, enc_mant}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (enc_rst_n !== 1'b1) begin n_err++; $display("FAIL rst_release_enc_rst_n: got %b want 1", enc_rst_n); end
  endtask

  task automatic test_single();
    bit got;
    int cyc;
    exp_t e;
    rand_fields();
    bus.req_sign[1] = 1'b0;
    bus.req_k[11:6] = 6'd0;
    bus.req_exp[5:3] = 3'b101;
    bus.req_mant[63:32] = 32'hA000_0000;
    lat = 3;
    start_cnt = 0;
    @(negedge clk); bus.req_valid = 3'b010; #1;
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_err++; $display("FAIL single_req_ready: got %b want 010", bus.req_ready); end
    @(negedge clk); bus.req_valid = '0;
    n_cmp++; if ({enc_start, busy, bus.req_ready} !== 5'b11_000) begin n_err++; $display("FAIL single_launch: got start=%b busy=%b ready=%b want 1/1/000", enc_start, busy, bus.req_ready); end
    n_cmp++; if ({enc_sign, enc_k, enc_exp, enc_mant} !== {1'b0, 6'd0, 3'b101, 32'hA000_0000}) begin n_err++; $display("FAIL single_operands: got %h", {enc_sign, enc_k, enc_exp, enc_mant}); end
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin @(negedge clk); cyc++; if (bus.res_valid) got = 1'b1; end
    n_cmp++;
    if (!got || sb.size() == 0) begin n_err++; $display("FAIL single_result: got=%b sb=%0d want result", got, sb.size()); end
    else begin
      e = sb.pop_front();
      if ({bus.res_tag, bus.res_posit, bus.res_err} !== {e.tag, e.posit, 1'b0}) begin n_err++; $display("FAIL single_result: got tag=%0d posit=%h err=%b want tag=%0d posit=%h err=0", bus.res_tag, bus.res_posit, bus.res_err, e.tag, e.posit); end
    end
    n_cmp++; if (bus.res_posit !== 32'h5680_0000) begin n_err++; $display("FAIL single_posit_const: got %h want 56800000", bus.res_posit); end
    n_cmp++; if (cyc != lat + 2) begin n_err++; $display("FAIL single_latency: got %0d want %0d", cyc, lat + 2); end
    n_cmp++; if (start_cnt != 1) begin n_err++; $display("FAIL single_start_pulses: got %0d want 1", start_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL single_consumed: got %b want 0", bus.res_valid); end
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] want [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    exp_t e;
    rand_fields();
    lat = 2;
    @(negedge clk); bus.req_valid = 3'b011;
    for (int j = 0; j < 4; j++) begin
      bit got;
      int cyc;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 40) begin @(negedge clk); cyc++; if (bus.res_valid) got = 1'b1; end
      if (j == 3) bus.req_valid = '0;
      n_cmp++;
      if (!got || sb.size() == 0) begin n_err++; $display("FAIL rr_result%0d: got=%b sb=%0d want result", j, got, sb.size()); end
      else begin
        e = sb.pop_front();
        if ({bus.res_tag, bus.res_posit, bus.res_err} !== {e.tag, e.posit, 1'b0}) begin n_err++; $display("FAIL rr_result%0d: got tag=%0d posit=%h err=%b want tag=%0d posit=%h err=0", j, bus.res_tag, bus.res_posit, bus.res_err, e.tag, e.posit); end
      end
      n_cmp++; if (bus.res_tag !== want[j]) begin n_err++; $display("FAIL rr_order%0d: got tag %0d want %0d", j, bus.res_tag, want[j]); end
    end
  endtask

  task automatic test_stall();
    bit got;
    int cyc;
    exp_t e;
    logic [31:0] cap_p;
    logic [TW-1:0] cap_t;
    rand_fields();
    lat = 4;
    run_req(3'b100, 30, got, cyc);
    bus.res_ready = 1'b0;
    bus.req_valid = 3'b001;
    cap_p = bus.res_posit;
    cap_t = bus.res_tag;
    start_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.res_valid, bus.res_posit, bus.res_tag, bus.req_ready, enc_start} !== {1'b1, cap_p, cap_t, 3'b000, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got valid=%b posit=%h tag=%0d ready=%b start=%b want 1/%h/%0d/000/0", c, bus.res_valid, bus.res_posit, bus.res_tag, bus.req_ready, enc_start, cap_p, cap_t);
      end
    end
    n_cmp++; if (start_cnt != 0) begin n_err++; $display("FAIL stall_no_start: got %0d starts want 0", start_cnt); end
    bus.res_ready = 1'b1;
    bus.req_valid = '0;
    n_cmp++;
    if (!got || sb.size() == 0) begin n_err++; $display("FAIL stall_result: got=%b sb=%0d want result", got, sb.size()); end
    else begin
      e = sb.pop_front();
      if ({bus.res_tag, bus.res_posit, bus.res_err} !== {e.tag, e.posit, 1'b0} || e.tag !== 3'd2) begin n_err++; $display("FAIL stall_result: got tag=%0d posit=%h err=%b want tag=%0d posit=%h err=0", bus.res_tag, bus.res_posit, bus.res_err, e.tag, e.posit); end
    end
  endtask

  task automatic test_reset_wait();
    bit got;
    int cyc;
    int seen;
    exp_t e;
    rand_fields();
    lat = 20;
    @(negedge clk); bus.req_valid = 3'b010;
    @(negedge clk); bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.res_valid, busy, enc_rst_n} !== 3'b000) begin n_err++; $display("FAIL rstwait_state: got valid=%b busy=%b enc_rst_n=%b want 0/0/0", bus.res_valid, busy, enc_rst_n); end
    rst = 1'b0;
    sb.delete();
    lat = 3;
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.res_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstwait_no_result: got %0d valid cycles want 0", seen); end
    run_req(3'b111, 30, got, cyc);
    n_cmp++;
    if (!got || sb.size() == 0) begin n_err++; $display("FAIL rstwait_ptr: got=%b sb=%0d want result", got, sb.size()); end
    else begin
      e = sb.pop_front();
      if ({bus.res_tag, bus.res_posit, bus.res_err} !== {3'd0, e.posit, 1'b0}) begin n_err++; $display("FAIL rstwait_ptr: got tag=%0d posit=%h err=%b want tag=0 posit=%h err=0", bus.res_tag, bus.res_posit, bus.res_err, e.posit); end
    end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] vv   [3] = '{3'b100, 3'b001, 3'b111};
    logic [TW-1:0] want [3] = '{3'd2, 3'd0, 3'd1};
    for (int j = 0; j < 3; j++) begin
      bit got;
      int cyc;
      exp_t e;
      rand_fields();
      lat = 1 + j;
      run_req(vv[j], 30, got, cyc);
      n_cmp++;
      if (!got || sb.size() == 0) begin n_err++; $display("FAIL wrap%0d: got=%b sb=%0d want result", j, got, sb.size()); end
      else begin
        e = sb.pop_front();
        if ({bus.res_tag, bus.res_posit, bus.res_err} !== {want[j], e.posit, 1'b0}) begin n_err++; $display("FAIL wrap%0d: got tag=%0d posit=%h err=%b want tag=%0d posit=%h err=0", j, bus.res_tag, bus.res_posit, bus.res_err, want[j], e.posit); end
      end
    end
  endtask

`ifdef POSIT_ENC_WDOG_EN
  task automatic test_wdog();
    bit got;
    int cyc;
    exp_t e;
    rand_fields();
    lat = 2;
    suppress = 1'b1;
    rstn_low = 0;
    run_req(3'b010, 40, got, cyc);
    n_cmp++; if (!got || {bus.res_tag, bus.res_posit, bus.res_err} !== {3'd1, 32'h8000_0000, 1'b1}) begin n_err++; $display("FAIL wdog_result: got=%b tag=%0d posit=%h err=%b want 1/80000000/1", got, bus.res_tag, bus.res_posit, bus.res_err); end
    n_cmp++; if (cyc != WD + 1) begin n_err++; $display("FAIL wdog_latency: got %0d want %0d", cyc, WD + 1); end
    if (sb.size() != 0) e = sb.pop_front();
    suppress = 1'b0;
    @(negedge clk);
    n_cmp++; if (rstn_low != 1) begin n_err++; $display("FAIL wdog_enc_rst_pulse: got %0d low cycles want 1", rstn_low); end
    run_req(3'b001, 30, got, cyc);
    n_cmp++;
    if (!got || sb.size() == 0) begin n_err++; $display("FAIL wdog_recover: got=%b sb=%0d want result", got, sb.size()); end
    else begin
      e = sb.pop_front();
      if ({bus.res_tag, bus.res_posit, bus.res_err} !== {e.tag, e.posit, 1'b0}) begin n_err++; $display("FAIL wdog_recover: got tag=%0d posit=%h err=%b want tag=%0d posit=%h err=0", bus.res_tag, bus.res_posit, bus.res_err, e.tag, e.posit); end
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_wait();
    test_wrap();
`ifdef POSIT_ENC_WDOG_EN
    test_wdog();
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
